encoder42_sync: RTL and testbench
=================================

ENCODER42_SYNC -- requirements
Module: encoder42_sync

Interface
REQ-001 The module SHALL have parameter MSB_FIRST, default 1; 1 means bit 3 has highest priority, 0 means bit 0 has highest priority.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port req, input, 4 bits: request lines, one per code; multi-hot is allowed.
REQ-005 The module SHALL have port in_valid, input, 1 bit: req is sampled only when this is 1.
REQ-006 The module SHALL have port out_code, output, 2 bits: encoded index {a,b}, a = MSB; 00->bit0, 01->bit1, 10->bit2, 11->bit3.
REQ-007 The module SHALL have port out_valid, output, 1 bit: out_code holds a pending request.
REQ-008 The module SHALL have port out_ready, input, 1 bit: consumer accepts out_code when out_valid=1.
REQ-009 The module SHALL have port pend_cnt, output, 3 bits: number of pending request bits, 0..4.
REQ-010 The module SHALL have port ovf, output, 1 bit: one-cycle pulse when a sampled request is lost.

Function
REQ-011 The module SHALL keep a 4-bit pending register pend, with bit i set while request i awaits output.
REQ-012 A handshake SHALL occur in any cycle with out_valid=1 and out_ready=1; the bit indexed by out_code is then "cleared".
REQ-013 Next pend SHALL be (pend & ~cleared_mask) | (in_valid ? req : 0000).
REQ-014 A req bit arriving in the same cycle that its pend bit is cleared SHALL stay set, with no ovf.
REQ-015 ovf SHALL pulse high for the next cycle if in_valid=1 and any req bit i has pend[i]=1 that is not cleared in that cycle.
REQ-016 The FSM SHALL have two states, IDLE and SHOW; out_valid=1 exactly in SHOW.
REQ-017 In IDLE with pend!=0, the next edge SHALL load out_code = highest-priority set bit of pend (per MSB_FIRST) and enter SHOW.
REQ-018 In IDLE with pend=0, the FSM SHALL stay in IDLE; out_code holds its last value.
REQ-019 In SHOW without a handshake, out_code and out_valid SHALL hold stable, regardless of new requests, including higher-priority ones.
REQ-020 In SHOW with a handshake, if (pend & ~cleared_mask)!=0 the next edge SHALL load the highest-priority remaining bit and stay in SHOW (no bubble).
REQ-021 Otherwise, on a handshake the FSM SHALL return to IDLE; requests arriving in the handshake cycle are presented after one IDLE cycle.
REQ-022 Latency: req sampled at edge N sets pend at N; out_valid SHALL rise at edge N+1 when the FSM is IDLE.
REQ-023 pend_cnt SHALL be the registered popcount of pend, updating on the same edge as pend.
REQ-024 An out_ready asserted while out_valid=0 SHALL have no effect.

Reset
REQ-025 When rst=1 at an edge: pend=0000, out_valid=0, out_code=00, pend_cnt=000, ovf=0, FSM=IDLE.
REQ-026 Reset SHALL take priority over in_valid and handshakes in the same cycle; requests sampled during reset are dropped without ovf.
REQ-027 Reset asserted while in SHOW SHALL abort the presented code; it is not re-presented after reset.

Verification
REQ-028 Single request: in_valid=1, req=0100 for one cycle, out_ready=1 -> out_valid for one cycle with out_code=10; pend_cnt goes 1 then 0.
REQ-029 Priority drain with MSB_FIRST=1: req=1011, out_ready=1 -> out_code 11, 01, 00 on consecutive cycles with no bubble; out_valid low after; pend_cnt 3,2,1,0.
REQ-030 Priority drain with MSB_FIRST=0: same stimulus -> out_code 00, 01, 11.
REQ-031 Backpressure: out_ready=0, req=0001 presented, then req=1000 arrives -> out_code stays 00 until out_ready=1, then 11; pend_cnt=2 while stalled.
REQ-032 Overflow and clear-collision: pend[2]=1 with out_code≠10 and req=0100 -> ovf=1 for one cycle, pend_cnt unchanged; req=0100 in the handshake cycle of code 10 -> ovf=0 and code 10 is presented again.
REQ-033 Reset mid-operation: rst=1 while out_valid=1 with pend=1110 -> next cycle all outputs 0 and pend_cnt=000; req=1111 with rst=1 leaves pend=0000.

Source files
------------

// File: rtl/encoder42_sync.sv
// encoder42_sync: 4-to-2 priority encoder with pending-request memory.
// Requests are latched, then drained one code at a time over a valid/ready handshake.
module encoder42_sync #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       in_valid,
    output logic [1:0] out_code,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] pend_cnt,
    output logic       ovf
);

    typedef enum logic {
        IDLE,
        SHOW
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] pend;
    logic [3:0] pend_nxt;
    logic [3:0] clr;
    logic [3:0] rem;
    logic [3:0] incoming;
    logic [1:0] code_nxt;
    logic [2:0] cnt_nxt;
    logic       hs;
    logic       ovf_nxt;

    // Index of the winning set bit; the last hit in the scan order wins.
    function automatic logic [1:0] pick(input logic [3:0] v);
        logic [1:0] r;
        r = 2'b00;
        if (MSB_FIRST) begin
            for (int i = 0; i < 4; i++)
                if (v[i]) r = 2'(i);
        end else begin
            for (int i = 3; i >= 0; i--)
                if (v[i]) r = 2'(i);
        end
        return r;
    endfunction

    function automatic logic [2:0] popcount(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]}
             + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    assign out_valid = (state == SHOW);

    // Pending-set update: drop the handed-off bit, merge new requests.
    // A request landing on a still-pending bit is lost and flagged.
    always_comb begin
        hs       = out_valid & out_ready;
        clr      = hs ? (4'b0001 << out_code) : 4'b0000;
        rem      = pend & ~clr;
        incoming = in_valid ? req : 4'b0000;
        pend_nxt = rem | incoming;
        ovf_nxt  = |(incoming & rem);
        cnt_nxt  = popcount(pend_nxt);
    end

    // Presentation FSM: the shown code is frozen until it is accepted,
    // then the next remaining bit follows with no idle gap.
    always_comb begin
        state_nxt = state;
        code_nxt  = out_code;
        unique case (state)
            IDLE: begin
                if (|pend) begin
                    code_nxt  = pick(pend);
                    state_nxt = SHOW;
                end
            end
            SHOW: begin
                if (hs) begin
                    if (|rem) begin
                        code_nxt = pick(rem);
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Datapath registers; reset discards everything, including a shown code.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= 4'b0000;
            out_code <= 2'b00;
            pend_cnt <= 3'b000;
            ovf      <= 1'b0;
        end else begin
            pend     <= pend_nxt;
            out_code <= code_nxt;
            pend_cnt <= cnt_nxt;
            ovf      <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_encoder42_sync.sv
// tb_encoder42_sync: drives both priority orders with identical stimulus
// and compares every output against a per-instance behavioural model.
module tb_encoder42_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       in_valid;
    logic       out_ready;

    logic [1:0] code_h, code_l;
    logic       vld_h, vld_l;
    logic [2:0] cnt_h, cnt_l;
    logic       ovf_h, ovf_l;

    int tests = 0;
    int fails = 0;

    // Model state, index 0: LSB priority, index 1: MSB priority.
    bit m_pend [2][4];
    bit m_vld  [2];
    int m_code [2];
    int m_cnt  [2];
    bit m_ovf  [2];

    always #5 clk = ~clk;

    encoder42_sync #(.MSB_FIRST(1'b1)) dut_h (
        .clk(clk), .rst(rst), .req(req), .in_valid(in_valid),
        .out_code(code_h), .out_valid(vld_h), .out_ready(out_ready),
        .pend_cnt(cnt_h), .ovf(ovf_h)
    );

    encoder42_sync #(.MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .req(req), .in_valid(in_valid),
        .out_code(code_l), .out_valid(vld_l), .out_ready(out_ready),
        .pend_cnt(cnt_l), .ovf(ovf_l)
    );

    function automatic int best(input int m, input bit v [4]);
        if (m == 1) begin
            for (int i = 3; i >= 0; i--) if (v[i]) return i;
        end else begin
            for (int i = 0; i < 4; i++) if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model(input int m, input bit r, input bit [3:0] rq,
                         input bit iv, input bit rd);
        bit hs;
        bit keep [4];
        bit np [4];
        bit lost;
        int n;
        if (r) begin
            for (int i = 0; i < 4; i++) m_pend[m][i] = 0;
            m_vld[m] = 0; m_code[m] = 0; m_cnt[m] = 0; m_ovf[m] = 0;
            return;
        end
        hs = m_vld[m] && rd;
        lost = 0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            keep[i] = m_pend[m][i] && !(hs && m_code[m] == i);
            np[i] = keep[i] || (iv && rq[i]);
            if (iv && rq[i] && keep[i]) lost = 1;
            if (np[i]) n++;
        end
        if (!m_vld[m]) begin
            if (best(m, m_pend[m]) >= 0) begin
                m_code[m] = best(m, m_pend[m]);
                m_vld[m] = 1;
            end
        end else if (hs) begin
            if (best(m, keep) >= 0) m_code[m] = best(m, keep);
            else m_vld[m] = 0;
        end
        for (int i = 0; i < 4; i++) m_pend[m][i] = np[i];
        m_cnt[m] = n;
        m_ovf[m] = lost;
    endtask

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit [3:0] rq,
                        input bit iv, input bit rd);
        rst = r; req = rq; in_valid = iv; out_ready = rd;
        model(0, r, rq, iv, rd);
        model(1, r, rq, iv, rd);
        @(posedge clk);
        #1;
        check("msb.valid", int'(vld_h), int'(m_vld[1]));
        check("msb.code",  int'(code_h), m_code[1]);
        check("msb.cnt",   int'(cnt_h), m_cnt[1]);
        check("msb.ovf",   int'(ovf_h), int'(m_ovf[1]));
        check("lsb.valid", int'(vld_l), int'(m_vld[0]));
        check("lsb.code",  int'(code_l), m_code[0]);
        check("lsb.cnt",   int'(cnt_l), m_cnt[0]);
        check("lsb.ovf",   int'(ovf_l), int'(m_ovf[0]));
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; in_valid = 1'b0; out_ready = 1'b0;
        // reset state
        step(1, 4'b0000, 0, 0);
        step(1, 4'b0000, 0, 0);
        // single request
        step(0, 4'b0100, 1, 1);
        repeat (3) step(0, 4'b0000, 0, 1);
        // priority drain in both orders
        step(0, 4'b1011, 1, 1);
        repeat (5) step(0, 4'b0000, 0, 1);
        // backpressure with a later higher-priority arrival
        step(0, 4'b0001, 1, 0);
        step(0, 4'b1000, 1, 0);
        repeat (2) step(0, 4'b0000, 0, 0);
        repeat (4) step(0, 4'b0000, 0, 1);
        // overflow, then request colliding with its own handshake
        step(0, 4'b1000, 1, 0);
        step(0, 4'b0100, 1, 0);
        step(0, 4'b0100, 1, 0);
        step(0, 4'b0100, 1, 1);
        step(0, 4'b0100, 1, 1);
        repeat (4) step(0, 4'b0000, 0, 1);
        // reset mid-operation, requests during reset dropped
        step(0, 4'b1110, 1, 0);
        step(0, 4'b0000, 0, 0);
        step(1, 4'b1111, 1, 1);
        repeat (3) step(0, 4'b0000, 0, 1);
        // stray ready while idle
        repeat (2) step(0, 4'b0000, 0, 1);
        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 49) == 0,
                 4'($urandom),
                 $urandom_range(0, 9) < 6,
                 $urandom_range(0, 9) < 6);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
